// File: rtl/jtag_pack.sv
// Shared JTAG IR definitions: opcode constants, chain indices and the instruction decode table.
package jtag_pack;

  localparam logic [7:0] OP_EXTEST  = 8'h00;
  localparam logic [7:0] OP_SAMPLE  = 8'h01;
  localparam logic [7:0] OP_PRELOAD = 8'h02;
  localparam logic [7:0] OP_IDCODE  = 8'h04;
  localparam logic [7:0] OP_IMEM    = 8'h80;
  localparam logic [7:0] OP_SC01    = 8'h81;

  typedef enum logic [2:0] {
    CH_BYPASS = 3'd0,
    CH_IDCODE = 3'd1,
    CH_BSCAN  = 3'd2,
    CH_IMEM   = 3'd3,
    CH_SC01   = 3'd4
  } chain_e;

  typedef struct packed {
    chain_e chain;
    logic   test_mode;
    logic   valid;
  } dec_t;

  // w is the IR width: opcodes that do not fit in w bits fall out of the table.
  function automatic dec_t jtag_decode(input logic [31:0] op, input int unsigned w);
    dec_t        d;
    logic [31:0] ones;
    ones = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    d    = '{chain: CH_BYPASS, test_mode: 1'b0, valid: 1'b1};
    if (op == ones)                              d.chain = CH_BYPASS;
    else if (w >= 8 && op == 32'(OP_IMEM))       d.chain = CH_IMEM;
    else if (w >= 8 && op == 32'(OP_SC01))       d.chain = CH_SC01;
    else begin
      case (op)
        32'(OP_EXTEST): begin
          d.chain     = CH_BSCAN;
          d.test_mode = 1'b1;
        end
        32'(OP_SAMPLE), 32'(OP_PRELOAD): d.chain = CH_BSCAN;
        32'd3, 32'd5, 32'd6, 32'd7:      d.chain = CH_BYPASS;
        32'(OP_IDCODE):                  d.chain = CH_IDCODE;
        default:                         d.valid = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/jtag_ir_shreg.sv
// IR capture/shift register with serial TDO; holds its value on the update strobe.
module jtag_ir_shreg #(
  parameter int IR_WIDTH = 8
) (
  input  logic                tck_i,
  input  logic                trst_ni,
  input  logic                tlr_i,
  input  logic                capture_i,
  input  logic                shift_i,
  input  logic                update_i,
  input  logic                tdi_i,
  output logic [IR_WIDTH-1:0] sr_o,
  output logic                tdo_o
);

  localparam logic [IR_WIDTH-1:0] CAPTURE_VAL = IR_WIDTH'(2'b01);

  logic [IR_WIDTH-1:0] r_sr;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni)          r_sr <= '0;
    else if (tlr_i)        r_sr <= '0;
    else if (!update_i) begin
      // update outranks shift/capture so the value being latched stays stable
      if (shift_i)         r_sr <= {tdi_i, r_sr[IR_WIDTH-1:1]};
      else if (capture_i)  r_sr <= CAPTURE_VAL;
    end
  end

  assign sr_o  = r_sr;
  assign tdo_o = r_sr[0];

endmodule

// File: rtl/jtag_ir_unit.sv
// JTAG instruction register, decode and per-chain DR strobe gating.
// Optional private-instruction lock is enabled by defining JTAG_PRIV_LOCK_EN.
module jtag_ir_unit
  import jtag_pack::*;
#(
  parameter int                  IR_WIDTH  = 8,
  parameter int                  NR_CHAINS = 5,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP = 'h04,
  parameter logic [IR_WIDTH-1:0] UNLOCK_OP = 'hA5
) (
  input  logic                         tck_i,
  input  logic                         trst_ni,
  input  logic                         tlr_i,
  input  logic                         ir_capture_i,
  input  logic                         ir_shift_i,
  input  logic                         ir_update_i,
  input  logic                         tdi_i,
  input  logic                         dr_capture_i,
  input  logic                         dr_shift_i,
  input  logic                         dr_update_i,
  output logic                         ir_tdo_o,
  output logic [IR_WIDTH-1:0]          ir_q_o,
  output logic [$clog2(NR_CHAINS)-1:0] sel_tdo_o,
  output logic [NR_CHAINS-1:0]         chain_capture_o,
  output logic [NR_CHAINS-1:0]         chain_shift_o,
  output logic [NR_CHAINS-1:0]         chain_update_o,
  output logic                         test_mode_o,
  output logic                         instr_valid_o,
  output logic                         lock_o
);

  localparam int SELW = $clog2(NR_CHAINS);

  logic [IR_WIDTH-1:0] w_sr;
  logic [IR_WIDTH-1:0] r_ir_q;
  logic                w_unlock_dec;
  dec_t                w_dec;

  jtag_ir_shreg #(.IR_WIDTH(IR_WIDTH)) u_shreg (
    .tck_i     (tck_i),
    .trst_ni   (trst_ni),
    .tlr_i     (tlr_i),
    .capture_i (ir_capture_i),
    .shift_i   (ir_shift_i),
    .update_i  (ir_update_i),
    .tdi_i     (tdi_i),
    .sr_o      (w_sr),
    .tdo_o     (ir_tdo_o)
  );

`ifdef JTAG_PRIV_LOCK_EN
  // Narrow IRs cannot encode private opcodes, so the lock never bites there.
  localparam bit PRIV_EN = (IR_WIDTH >= 8);

  logic r_lock;
  logic w_priv;

  assign w_priv = PRIV_EN && w_sr[IR_WIDTH-1] && (w_sr != '1);

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_ir_q <= IDCODE_OP;
      r_lock <= 1'b1;
    end else if (tlr_i) begin
      r_ir_q <= IDCODE_OP;
      r_lock <= 1'b1;
    end else if (ir_update_i) begin
      if (PRIV_EN && w_sr == UNLOCK_OP) begin
        r_lock <= 1'b0;
        r_ir_q <= w_sr;
      end else if (r_lock && w_priv) begin
        r_ir_q <= '1;
      end else begin
        r_ir_q <= w_sr;
      end
    end
  end

  assign lock_o       = r_lock;
  assign w_unlock_dec = PRIV_EN && (r_ir_q == UNLOCK_OP);
`else
  logic w_unused_unlock;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni)         r_ir_q <= IDCODE_OP;
    else if (tlr_i)       r_ir_q <= IDCODE_OP;
    else if (ir_update_i) r_ir_q <= w_sr;
  end

  assign lock_o          = 1'b0;
  assign w_unlock_dec    = 1'b0;
  assign w_unused_unlock = ^UNLOCK_OP;
`endif

  always_comb begin
    w_dec = jtag_decode(32'(r_ir_q), IR_WIDTH);
    if (w_unlock_dec) w_dec = '{chain: CH_BYPASS, test_mode: 1'b0, valid: 1'b1};
  end

  assign ir_q_o        = r_ir_q;
  assign sel_tdo_o     = SELW'(w_dec.chain);
  assign test_mode_o   = w_dec.test_mode;
  assign instr_valid_o = w_dec.valid;

  // Strobes follow the current instruction, so an update edge only redirects the next cycle.
  for (genvar k = 0; k < NR_CHAINS; k++) begin : g_chain
    logic w_hit;
    assign w_hit              = trst_ni && (sel_tdo_o == SELW'(k));
    assign chain_capture_o[k] = dr_capture_i & w_hit;
    assign chain_shift_o[k]   = dr_shift_i & w_hit;
    assign chain_update_o[k]  = dr_update_i & w_hit;
  end

endmodule
